// File: rtl/rf_rename_ckpt_pkg.sv
// Shared constants and types for the rename register file slice.
// The checkpoint store is only built when RF_CKPT_EN is defined.
package rf_rename_ckpt_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int ROB_W_DEF    = 4;
   localparam int NUM_CKPT_DEF = 4;

   typedef enum logic [1:0] {
      TBL_HOLD,
      TBL_FLUSH,
      TBL_RESTORE,
      TBL_UPDATE
   } tbl_op_e;

   function automatic int ckpt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rf_rename_ckpt_if.sv
// Decoder/ROB/branch-unit side bundle of the rename register file.
// master = pipeline control side, slave = the register file.
interface rf_rename_ckpt_if #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int ROB_W    = 4,
   parameter int NUM_CKPT = 4
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int CW = rf_rename_ckpt_pkg::ckpt_w(NUM_CKPT);

   logic             rdy;
   logic             flush;
   logic             stall;
   logic             dec_valid;
   logic             dec_wr;
   logic [RW-1:0]    dec_rd;
   logic [RW-1:0]    dec_rs1;
   logic [RW-1:0]    dec_rs2;
   logic [ROB_W-1:0] dec_tag;
   logic [XLEN-1:0]  rd_val1;
   logic [XLEN-1:0]  rd_val2;
   logic             rd_busy1;
   logic             rd_busy2;
   logic [ROB_W-1:0] rd_tag1;
   logic [ROB_W-1:0] rd_tag2;
   logic             cm_valid;
   logic [RW-1:0]    cm_rd;
   logic [XLEN-1:0]  cm_val;
   logic [ROB_W-1:0] cm_tag;
   logic             ckpt_take;
   logic [CW-1:0]    ckpt_id;
   logic             ckpt_full;
   logic             br_valid;
   logic [CW-1:0]    br_ckpt;
   logic             br_mispred;

   modport master (
      output rdy, flush, stall, dec_valid, dec_wr, dec_rd, dec_rs1, dec_rs2, dec_tag,
             cm_valid, cm_rd, cm_val, cm_tag, ckpt_take, br_valid, br_ckpt, br_mispred,
      input  rd_val1, rd_val2, rd_busy1, rd_busy2, rd_tag1, rd_tag2, ckpt_id, ckpt_full
   );

   modport slave (
      input  rdy, flush, stall, dec_valid, dec_wr, dec_rd, dec_rs1, dec_rs2, dec_tag,
             cm_valid, cm_rd, cm_val, cm_tag, ckpt_take, br_valid, br_ckpt, br_mispred,
      output rd_val1, rd_val2, rd_busy1, rd_busy2, rd_tag1, rd_tag2, ckpt_id, ckpt_full
   );

endinterface

// File: rtl/rf_rename_ckpt_store.sv
// Branch checkpoint store: busy/tag snapshots, slot valid bits, younger masks,
// free-slot encoder and commit-clear of live snapshots.
module rf_ckpt_store
   import rf_rename_ckpt_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ROB_W    = ROB_W_DEF,
   parameter int NUM_CKPT = NUM_CKPT_DEF,
   localparam int RW      = $clog2(NUM_REGS),
   localparam int CW      = ckpt_w(NUM_CKPT)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           flush,
   input  logic                           cm_valid,
   input  logic [RW-1:0]                  cm_rd,
   input  logic [ROB_W-1:0]               cm_tag,
   input  logic                           take_req,
   input  logic [NUM_REGS-1:0]            tbl_busy,
   input  logic [NUM_REGS-1:0][ROB_W-1:0] tbl_tag,
   input  logic                           br_valid,
   input  logic [CW-1:0]                  br_ckpt,
   input  logic                           br_mispred,
   output logic [CW-1:0]                  ckpt_id,
   output logic                           ckpt_full,
   output logic                           mispred,
   output logic [NUM_REGS-1:0]            rcv_busy,
   output logic [NUM_REGS-1:0][ROB_W-1:0] rcv_tag
);

   logic [NUM_CKPT-1:0]                          vld_q, vld_d;
   logic [NUM_CKPT-1:0][NUM_CKPT-1:0]            young_q, young_d;
   logic [NUM_CKPT-1:0][NUM_REGS-1:0]            sbusy_q, sbusy_d, sbusy_cc;
   logic [NUM_CKPT-1:0][NUM_REGS-1:0][ROB_W-1:0] stag_q, stag_d;
   logic [NUM_CKPT-1:0]                          kill;
   logic [CW-1:0]                                free_id;
   logic                                         found;

   always_comb begin
      free_id = '0;
      found   = 1'b0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
         if (!vld_q[s] && !found) begin
            free_id = CW'(s);
            found   = 1'b1;
         end
      end
   end

   assign ckpt_id   = free_id;
   assign ckpt_full = &vld_q;
   assign mispred   = br_valid && br_mispred;

   always_comb begin
      sbusy_cc = sbusy_q;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
         if (cm_valid && cm_rd != '0 && stag_q[s][cm_rd] == cm_tag)
            sbusy_cc[s][cm_rd] = 1'b0;
      end
   end

   assign rcv_busy = sbusy_cc[br_ckpt];
   assign rcv_tag  = stag_q[br_ckpt];

   always_comb begin
      vld_d   = vld_q;
      young_d = young_q;
      sbusy_d = sbusy_q;
      stag_d  = stag_q;
      kill    = young_q[br_ckpt];
      kill[br_ckpt] = 1'b1;
      if (rdy) begin
         sbusy_d = sbusy_cc;
         if (flush) begin
            vld_d   = '0;
            young_d = '0;
         end else if (mispred) begin
            vld_d = vld_q & ~kill;
            for (int unsigned s = 0; s < NUM_CKPT; s++)
               young_d[s] = kill[s] ? '0 : (young_q[s] & ~kill);
         end else begin
            if (br_valid) begin
               vld_d[br_ckpt]   = 1'b0;
               young_d[br_ckpt] = '0;
               for (int unsigned s = 0; s < NUM_CKPT; s++)
                  young_d[s][br_ckpt] = 1'b0;
            end
            // The free slot is chosen from pre-edge valid bits, so a slot
            // released above is never the one taken here.
            if (take_req && !ckpt_full) begin
               for (int unsigned s = 0; s < NUM_CKPT; s++)
                  if (vld_d[s]) young_d[s][free_id] = 1'b1;
               vld_d[free_id]   = 1'b1;
               young_d[free_id] = '0;
               sbusy_d[free_id] = tbl_busy;
               stag_d[free_id]  = tbl_tag;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         young_q <= '0;
         sbusy_q <= '0;
         stag_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         young_q <= young_d;
         sbusy_q <= sbusy_d;
         stag_q  <= stag_d;
      end
   end

endmodule

// File: rtl/rf_rename_ckpt.sv
// Architectural register file with rename tags and optional branch checkpoints.
// Define RF_CKPT_EN to build the checkpoint store; otherwise recovery is flush-only.
module rf_rename_ckpt
   import rf_rename_ckpt_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ROB_W    = ROB_W_DEF,
   parameter int NUM_CKPT = NUM_CKPT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   rf_rename_ckpt_if.slave bus
);
   localparam int RW = $clog2(NUM_REGS);

   logic [NUM_REGS-1:0][XLEN-1:0]  val_q, val_d;
   logic [NUM_REGS-1:0]            busy_q, busy_d, busy_cc;
   logic [NUM_REGS-1:0][ROB_W-1:0] tag_q, tag_d;
   logic [NUM_REGS-1:0]            rcv_busy;
   logic [NUM_REGS-1:0][ROB_W-1:0] rcv_tag;
   logic                           mispred;
   logic                           cm_hit;
   logic                           ren;
   tbl_op_e                        op;

   assign cm_hit = bus.cm_valid && bus.cm_rd != '0;
   assign ren    = bus.dec_valid && !bus.stall && bus.dec_wr && bus.dec_rd != '0;

   // Sources see the pre-edge table plus the same-cycle commit.
   always_comb begin
      bus.rd_val1  = '0;
      bus.rd_busy1 = 1'b0;
      bus.rd_tag1  = '0;
      bus.rd_val2  = '0;
      bus.rd_busy2 = 1'b0;
      bus.rd_tag2  = '0;
      if (bus.dec_rs1 != '0) begin
         bus.rd_val1  = (bus.cm_valid && bus.cm_rd == bus.dec_rs1) ? bus.cm_val : val_q[bus.dec_rs1];
         bus.rd_busy1 = busy_q[bus.dec_rs1] &&
                        !(bus.cm_valid && bus.cm_rd == bus.dec_rs1 && bus.cm_tag == tag_q[bus.dec_rs1]);
         bus.rd_tag1  = tag_q[bus.dec_rs1];
      end
      if (bus.dec_rs2 != '0) begin
         bus.rd_val2  = (bus.cm_valid && bus.cm_rd == bus.dec_rs2) ? bus.cm_val : val_q[bus.dec_rs2];
         bus.rd_busy2 = busy_q[bus.dec_rs2] &&
                        !(bus.cm_valid && bus.cm_rd == bus.dec_rs2 && bus.cm_tag == tag_q[bus.dec_rs2]);
         bus.rd_tag2  = tag_q[bus.dec_rs2];
      end
   end

   always_comb begin
      busy_cc = busy_q;
      if (cm_hit && tag_q[bus.cm_rd] == bus.cm_tag)
         busy_cc[bus.cm_rd] = 1'b0;
   end

`ifdef RF_CKPT_EN
   rf_ckpt_store #(
      .NUM_REGS (NUM_REGS),
      .ROB_W    (ROB_W),
      .NUM_CKPT (NUM_CKPT)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .rdy        (bus.rdy),
      .flush      (bus.flush),
      .cm_valid   (bus.cm_valid),
      .cm_rd      (bus.cm_rd),
      .cm_tag     (bus.cm_tag),
      .take_req   (bus.dec_valid && bus.ckpt_take && !bus.stall),
      .tbl_busy   (busy_cc),
      .tbl_tag    (tag_q),
      .br_valid   (bus.br_valid),
      .br_ckpt    (bus.br_ckpt),
      .br_mispred (bus.br_mispred),
      .ckpt_id    (bus.ckpt_id),
      .ckpt_full  (bus.ckpt_full),
      .mispred    (mispred),
      .rcv_busy   (rcv_busy),
      .rcv_tag    (rcv_tag)
   );
`else
   logic unused_ckpt;
   assign unused_ckpt   = ^{bus.ckpt_take, bus.br_valid, bus.br_ckpt, bus.br_mispred};
   assign bus.ckpt_id   = '0;
   assign bus.ckpt_full = 1'b0;
   assign mispred       = 1'b0;
   assign rcv_busy      = '0;
   assign rcv_tag       = '0;
`endif

   always_comb begin
      op = TBL_HOLD;
      if (bus.rdy) begin
         if (bus.flush)   op = TBL_FLUSH;
         else if (mispred) op = TBL_RESTORE;
         else              op = TBL_UPDATE;
      end
   end

   always_comb begin
      val_d  = val_q;
      busy_d = busy_q;
      tag_d  = tag_q;
      if (bus.rdy && cm_hit)
         val_d[bus.cm_rd] = bus.cm_val;
      case (op)
         TBL_FLUSH: busy_d = '0;
         TBL_RESTORE: begin
            busy_d = rcv_busy;
            tag_d  = rcv_tag;
         end
         TBL_UPDATE: begin
            busy_d = busy_cc;
            if (ren) begin
               busy_d[bus.dec_rd] = 1'b1;
               tag_d[bus.dec_rd]  = bus.dec_tag;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q  <= '0;
         busy_q <= '0;
         tag_q  <= '0;
      end else begin
         val_q  <= val_d;
         busy_q <= busy_d;
         tag_q  <= tag_d;
      end
   end

endmodule
